// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//
// Purpose:
//   Consumer side of the subtract-unit flag interface (C, Z, V, S). It takes
//   one branch request from decode and waits for the matching compare flags.
//   It then evaluates the branch condition and hands a registered
//   taken/redirect decision to fetch. A request that never sees its flags
//   is resolved as not-taken after a bounded wait, with a one-cycle
//   timeout_err pulse alongside that decision.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset (overrides flush)
//   flags_valid  flag_c/z/v/s carry a valid compare result this cycle
//   flag_c       borrow of input1-input2 (input1 < input2 unsigned)
//   flag_z       input1-input2 == 0
//   flag_v       signed overflow of input1-input2
//   flag_s       MSB of input1-input2
//   br_valid     branch request present
//   br_cond      condition code: EQ, NE, LT, GE, LTU, GEU, ALWAYS, NEVER
//   br_target    branch target PC
//   br_ready     request accepted when br_valid & br_ready
//   stall        fetch cannot take the decision this cycle
//   flush        kill any in-flight branch
//   taken_valid  decision valid, held while stall
//   taken        branch condition evaluated true
//   redirect_pc  br_target when taken, otherwise 0
//   timeout_err  one-cycle pulse on a forced not-taken decision
// ---------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flags_valid,
  input  logic                  flag_c,
  input  logic                  flag_z,
  input  logic                  flag_v,
  input  logic                  flag_s,
  input  logic                  br_valid,
  input  logic [2:0]            br_cond,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  br_ready,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  taken_valid,
  output logic                  taken,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESOLVE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [2:0]            cond_q;
  logic [ADDR_WIDTH-1:0] target_q;
  logic                  live_idle;
  logic                  live_wait;

  function automatic logic eval_cond(input logic [2:0] cond, input logic c,
                                     input logic z, input logic v, input logic s);
    logic res;
    case (cond)
      3'd0:    res = z;
      3'd1:    res = !z;
      3'd2:    res = s ^ v;
      3'd3:    res = !(s ^ v);
      3'd4:    res = c;
      3'd5:    res = !c;
      3'd6:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // In IDLE the condition comes straight from decode; in WAIT it comes from
  // the captured copy, since decode has moved on by then.
  always_comb begin
    live_idle = eval_cond(br_cond, flag_c, flag_z, flag_v, flag_s);
    live_wait = eval_cond(cond_q, flag_c, flag_z, flag_v, flag_s);
    cnt_next  = wait_cnt + CNT_W'(1);
  end

  assign br_ready = (state == S_IDLE);

  // Single FSM. Priority is rst > flush > (in WAIT) flags > timeout.
  // A timeout fires when the incremented count reaches WAIT_LIMIT-1. The
  // decision therefore lands WAIT_LIMIT cycles after the request was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      taken_valid <= 1'b0;
      taken       <= 1'b0;
      redirect_pc <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      cond_q      <= '0;
      target_q    <= '0;
    end else if (flush) begin
      state       <= S_IDLE;
      taken_valid <= 1'b0;
      taken       <= 1'b0;
      redirect_pc <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_valid) begin
            cond_q   <= br_cond;
            target_q <= br_target;
            wait_cnt <= '0;
            if (flags_valid) begin
              state       <= S_RESOLVE;
              taken_valid <= 1'b1;
              taken       <= live_idle;
              redirect_pc <= live_idle ? br_target : '0;
              timeout_err <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flags_valid) begin
            state       <= S_RESOLVE;
            taken_valid <= 1'b1;
            taken       <= live_wait;
            redirect_pc <= live_wait ? target_q : '0;
            timeout_err <= 1'b0;
          end else if (cnt_next >= CNT_LAST) begin
            state       <= S_RESOLVE;
            taken_valid <= 1'b1;
            taken       <= 1'b0;
            redirect_pc <= '0;
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= cnt_next;
          end
        end
        S_RESOLVE: begin
          // timeout_err is a pulse; the rest holds for as long as stall does
          timeout_err <= 1'b0;
          if (!stall) begin
            state       <= S_IDLE;
            taken_valid <= 1'b0;
            taken       <= 1'b0;
            redirect_pc <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_unit
//
// Purpose:
//   Self-checking bench for branch_cond_unit. Random 8-bit operand pairs are
//   turned into C/Z/V/S flags. The expected branch outcome is computed by
//   comparing the operands directly, signed or unsigned as the condition
//   code demands.
// ---------------------------------------------------------------------------
module tb_branch_cond_unit;

  localparam int AW = 32;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flags_valid;
  logic          flag_c, flag_z, flag_v, flag_s;
  logic          br_valid;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_target;
  logic          br_ready;
  logic          stall;
  logic          flush;
  logic          taken_valid;
  logic          taken;
  logic [AW-1:0] redirect_pc;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  branch_cond_unit #(.ADDR_WIDTH(AW), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .flags_valid(flags_valid),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .flag_s(flag_s),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .br_ready(br_ready), .stall(stall), .flush(flush),
    .taken_valid(taken_valid), .taken(taken), .redirect_pc(redirect_pc),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Compare-unit model: flags of a-b on 8-bit operands
  task automatic set_flags(input logic [7:0] a, input logic [7:0] b);
    int d;
    logic [7:0] r;
    d = int'($signed(a)) - int'($signed(b));
    r = a - b;
    flag_c = (a < b);
    flag_z = (a == b);
    flag_v = (d > 127) || (d < -128);
    flag_s = r[7];
  endtask

  // Branch outcome straight from the operands
  function automatic logic ref_taken(input logic [2:0] cond, input logic [7:0] a,
                                     input logic [7:0] b);
    case (cond)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd3:    return $signed(a) >= $signed(b);
      3'd4:    return a < b;
      3'd5:    return a >= b;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flags_valid = 0; flag_c = 0; flag_z = 0; flag_v = 0; flag_s = 0;
    br_valid = 0; br_cond = 0; br_target = '0; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    step(); step();
    checks++;
    if ({taken_valid, taken, timeout_err} !== 3'b000 || redirect_pc !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got tv=%b tk=%b te=%b pc=%h want all 0",
               taken_valid, taken, timeout_err, redirect_pc);
    end
    rst = 0;
    step();
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_br_ready got %b want 1", br_ready);
    end
  endtask

  // Accept with same-cycle flags, optional stall hold, then release
  task automatic run_immediate(input string name, input logic [2:0] cond,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [AW-1:0] tgt, input int stall_cycles);
    logic          exp_tk;
    logic [AW-1:0] exp_pc;
    exp_tk = ref_taken(cond, a, b);
    exp_pc = exp_tk ? tgt : '0;
    br_valid = 1; br_cond = cond; br_target = tgt; flags_valid = 1;
    set_flags(a, b);
    stall = (stall_cycles > 0);
    step();
    br_valid = 0; flags_valid = 0;
    for (int i = 0; i <= stall_cycles; i++) begin
      if (i == stall_cycles) stall = 0;
      checks++;
      if (taken_valid !== 1'b1 || taken !== exp_tk || redirect_pc !== exp_pc ||
          br_ready !== 1'b0 || timeout_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s got tv=%b tk=%b pc=%h rdy=%b te=%b want 1 %b %h 0 0",
                 name, taken_valid, taken, redirect_pc, br_ready, timeout_err, exp_tk, exp_pc);
      end
      step();
    end
    checks++;
    if (taken_valid !== 1'b0 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_release got tv=%b rdy=%b want 0 1", name, taken_valid, br_ready);
    end
  endtask

  task automatic test_eq();
    run_immediate("eq_taken", 3'd0, 8'd17, 8'd17, 32'h0000_0040, 0);
  endtask

  task automatic test_signed_unsigned();
    run_immediate("lt_overflow", 3'd2, 8'h80, 8'h01, 32'h0000_1000, 0);
    run_immediate("ltu_not_taken", 3'd4, 8'd5, 8'd3, 32'h0000_2000, 0);
    run_immediate("never", 3'd7, 8'd1, 8'd1, 32'h0000_3000, 0);
  endtask

  task automatic test_random_immediate();
    for (int n = 0; n < 24; n++)
      run_immediate("rand_imm", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    $urandom, $urandom_range(0, 2));
  endtask

  // Flags arrive k cycles after the request was accepted
  task automatic run_late(input string name, input int k, input logic [2:0] cond,
                          input logic [7:0] a, input logic [7:0] b, input logic [AW-1:0] tgt);
    logic          exp_tk;
    logic [AW-1:0] exp_pc;
    exp_tk = ref_taken(cond, a, b);
    exp_pc = exp_tk ? tgt : '0;
    br_valid = 1; br_cond = cond; br_target = tgt; flags_valid = 0;
    step();
    br_valid = 0; br_cond = 3'($urandom); br_target = $urandom;
    for (int c = 1; c <= k; c++) begin
      checks++;
      if (br_ready !== 1'b0 || taken_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_wait cycle %0d got rdy=%b tv=%b want 0 0",
                 name, c, br_ready, taken_valid);
      end
      if (c == k) begin
        flags_valid = 1; set_flags(a, b);
      end
      step();
    end
    flags_valid = 0;
    checks++;
    if (taken_valid !== 1'b1 || taken !== exp_tk || redirect_pc !== exp_pc ||
        timeout_err !== 1'b0 || br_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s got tv=%b tk=%b pc=%h te=%b rdy=%b want 1 %b %h 0 0",
               name, taken_valid, taken, redirect_pc, timeout_err, br_ready, exp_tk, exp_pc);
    end
    step();
  endtask

  task automatic test_late_flags();
    run_late("late_ne", 3, 3'd1, 8'd9, 8'd4, 32'h0000_0080);
    run_late("late_last", WL - 1, 3'd6, 8'd0, 8'd0, 32'h0000_0100);
    for (int n = 0; n < 10; n++)
      run_late("late_rand", $urandom_range(1, WL - 1), 3'($urandom_range(0, 7)),
               8'($urandom), 8'($urandom), $urandom);
  endtask

  // No flags at all; stall keeps RESOLVE for hold_cycles extra cycles
  task automatic run_timeout(input string name, input int hold_cycles);
    int cyc;
    br_valid = 1; br_cond = 3'd6; br_target = 32'hDEAD_BEEF; flags_valid = 0;
    stall = (hold_cycles > 0);
    step();
    br_valid = 0;
    cyc = 1;
    while (taken_valid !== 1'b1 && cyc < 3 * WL) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== WL || taken_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_latency got %0d cycles tv=%b want %0d 1", name, cyc, taken_valid, WL);
    end
    for (int i = 0; i <= hold_cycles; i++) begin
      if (i == 1) begin
        flags_valid = 1; flag_z = 1; br_valid = 1;
      end
      if (i == hold_cycles) stall = 0;
      checks++;
      if (taken_valid !== 1'b1 || taken !== 1'b0 || redirect_pc !== '0 ||
          timeout_err !== (i == 0)) begin
        errors++;
        $display("[TB] FAIL %s_hold %0d got tv=%b tk=%b pc=%h te=%b want 1 0 0 %b",
                 name, i, taken_valid, taken, redirect_pc, timeout_err, (i == 0));
      end
      step();
    end
    idle_inputs();
    checks++;
    if (taken_valid !== 1'b0 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_release got tv=%b rdy=%b want 0 1", name, taken_valid, br_ready);
    end
  endtask

  task automatic test_timeout();
    run_timeout("timeout", 0);
  endtask

  task automatic test_stall();
    run_timeout("timeout_stall", 3);
  endtask

  task automatic test_flush();
    logic seen;
    br_valid = 1; br_cond = 3'd6; br_target = 32'h40; flags_valid = 0;
    step();
    br_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    seen = 0;
    for (int i = 0; i < WL + 4; i++) begin
      if (taken_valid) seen = 1;
      step();
    end
    checks++;
    if (seen !== 1'b0 || br_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_wait got seen=%b rdy=%b want 0 1", seen, br_ready);
    end
    br_valid = 1; br_cond = 3'd6; flags_valid = 1; flush = 1;
    step();
    idle_inputs();
    checks++;
    if (taken_valid !== 1'b0 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_idle got tv=%b rdy=%b want 0 1", taken_valid, br_ready);
    end
    br_valid = 1; br_cond = 3'd6; br_target = 32'h44; flags_valid = 1; stall = 1;
    step();
    br_valid = 0; flags_valid = 0; flush = 1;
    step();
    idle_inputs();
    checks++;
    if ({taken_valid, taken, timeout_err} !== 3'b000 || redirect_pc !== '0 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_resolve got tv=%b tk=%b te=%b pc=%h rdy=%b want 0 0 0 0 1",
               taken_valid, taken, timeout_err, redirect_pc, br_ready);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    br_valid = 1; br_cond = 3'd6; br_target = 32'h88; flags_valid = 1; stall = 1;
    step();
    br_valid = 0; flags_valid = 0;
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({taken_valid, taken, timeout_err} !== 3'b000 || redirect_pc !== '0 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_resolve got tv=%b tk=%b te=%b pc=%h rdy=%b want 0 0 0 0 1",
               taken_valid, taken, timeout_err, redirect_pc, br_ready);
    end
    stall = 0;
    br_valid = 1; flags_valid = 0;
    step();
    br_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < WL + 4; i++) begin
      if (taken_valid) seen = 1;
      step();
    end
    checks++;
    if (seen !== 1'b0 || br_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_wait got seen=%b rdy=%b want 0 1", seen, br_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_eq();
    test_signed_unsigned();
    test_random_immediate();
    test_late_flags();
    test_timeout();
    test_stall();
    test_flush();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
